// File: rtl/ma_pipeline_lsu.sv
// ---------------------------------------------------------------------------
// ma_pipeline_lsu
//   Memory-access stage that sits directly after EX. It takes the EX/MA
//   register fields, runs loads and stores over a req/gnt/rvalid data-memory
//   port, aligns and sign/zero-extends load data, picks the writeback value
//   and registers it into MA/WB. Upstream is stalled while a memory
//   transaction cannot complete at the coming edge.
//
// Parameters
//   MAX_WAIT      cycles spent in REQ/WAIT before the access is aborted
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   valid_in .. AddrD_in          EX/MA register fields
//   dmem_req/we/addr/be/wdata     data-memory request channel (out)
//   dmem_gnt                      request accepted this cycle (in)
//   dmem_rvalid/rdata             read response channel (in)
//   stall_out                     hold EX/MA and all earlier stages
//   valid_out .. WB_Result_out    MA/WB register
//   misalign_out                  one-cycle pulse: misaligned access dropped
//   bus_err_out                   one-cycle pulse: access aborted on timeout
//   state_dbg                     current FSM state (IDLE=0, REQ=1, WAIT=2)
//
// Handshake
//   A request is presented while dmem_req=1 and is held stable (address,
//   enables, data) until the cycle dmem_gnt=1; that cycle transfers it. For a
//   load, read data is taken only in a cycle after the grant, in WAIT, when
//   dmem_rvalid=1; rvalid in the grant cycle or outside WAIT is ignored.
// ---------------------------------------------------------------------------
module ma_pipeline_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        RegWEn_in,
  input  logic        MemRW_in,
  input  logic [1:0]  WBSel_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] DataB_in,
  input  logic [31:0] pcPlus4_in,
  input  logic [4:0]  AddrD_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        valid_out,
  output logic        RegWEn_out,
  output logic [4:0]  AddrD_out,
  output logic [31:0] WB_Result_out,
  output logic        misalign_out,
  output logic        bus_err_out,
  output logic [1:0]  state_dbg
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wait_cnt_q;

  logic           memop;
  logic           aligned;
  size_t          size;
  logic [1:0]     off;
  logic           timeout;

  logic           retire;
  logic           ret_wen;
  logic           ret_mis;
  logic           ret_err;

  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_data;
  logic [31:0]    wb_val;

  // -------------------------------------------------------------------------
  // Decode: a load is any valid non-store whose writeback selects memory.
  // -------------------------------------------------------------------------
  assign memop = valid_in & (MemRW_in | (WBSel_in == 2'b00));
  assign off   = ALU_Result_in[1:0];

  // Size comes from funct3[1:0]; unknown encodings fall back to a word.
  always_comb begin
    size = SZ_WORD;
    case (funct3_in[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~off[0];
      default: aligned = (off == 2'b00);
    endcase
  end

  // -------------------------------------------------------------------------
  // Request channel: address is word-aligned, store data is replicated into
  // every lane so the byte enables alone select what memory writes.
  // -------------------------------------------------------------------------
  assign dmem_addr = {ALU_Result_in[31:2], 2'b00};
  assign dmem_we   = dmem_req & MemRW_in;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = DataB_in;
    case (size)
      SZ_BYTE: begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{DataB_in[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = 4'b0011 << {off[1], 1'b0};
        dmem_wdata = {2{DataB_in[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = DataB_in;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load alignment and extension.
  // -------------------------------------------------------------------------
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
  end

  assign ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_data = dmem_rdata;
    case (funct3_in)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    wb_val = ALU_Result_in;
    case (WBSel_in)
      2'b00:   wb_val = ld_data;
      2'b10:   wb_val = pcPlus4_in;
      default: wb_val = ALU_Result_in;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: next state, request, retirement and stall.
  // The counter holds the number of earlier cycles already spent in REQ/WAIT,
  // so the MAX_WAIT-th such cycle is the one that aborts.
  // A grant or read response in the abort cycle still completes the access.
  // -------------------------------------------------------------------------
  assign timeout = (state_q != ST_IDLE) && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    retire   = 1'b0;
    ret_wen  = RegWEn_in;
    ret_mis  = 1'b0;
    ret_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (!memop) begin
            retire = 1'b1;
          end else if (!aligned) begin
            retire  = 1'b1;
            ret_wen = 1'b0;
            ret_mis = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
              if (MemRW_in) retire  = 1'b1;
              else          state_d = ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (MemRW_in) begin
            retire  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (timeout) begin
          retire  = 1'b1;
          ret_wen = 1'b0;
          ret_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          retire  = 1'b1;
          ret_wen = 1'b0;
          ret_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // High in every cycle where an aligned memory access cannot retire at the
  // coming edge; misaligned accesses and non-memory ops never stall.
  assign stall_out = memop & aligned & ~retire;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == ST_IDLE) ? '0 : wait_cnt_q + CW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // MA/WB register: non-retiring cycles insert a bubble; destination and
  // result hold their last retired values.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out     <= 1'b0;
      RegWEn_out    <= 1'b0;
      AddrD_out     <= 5'd0;
      WB_Result_out <= 32'd0;
      misalign_out  <= 1'b0;
      bus_err_out   <= 1'b0;
    end else if (retire) begin
      valid_out     <= 1'b1;
      RegWEn_out    <= ret_wen;
      AddrD_out     <= AddrD_in;
      WB_Result_out <= wb_val;
      misalign_out  <= ret_mis;
      bus_err_out   <= ret_err;
    end else begin
      valid_out     <= 1'b0;
      RegWEn_out    <= 1'b0;
      misalign_out  <= 1'b0;
      bus_err_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ma_pipeline_lsu.sv
// ---------------------------------------------------------------------------
// tb_ma_pipeline_lsu
//   Directed bench for ma_pipeline_lsu. The main instance uses the default
//   MAX_WAIT; a second instance with MAX_WAIT=4 shares the inputs and is only
//   observed in the timeout scenario.
// ---------------------------------------------------------------------------
module tb_ma_pipeline_lsu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT inputs ----------------
  logic        valid_in, RegWEn_in, MemRW_in;
  logic [1:0]  WBSel_in;
  logic [2:0]  funct3_in;
  logic [31:0] ALU_Result_in, DataB_in, pcPlus4_in;
  logic [4:0]  AddrD_in;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  // ---------------- main instance outputs ----------------
  logic        dmem_req, dmem_we, stall_out, valid_out, RegWEn_out;
  logic [31:0] dmem_addr, dmem_wdata, WB_Result_out;
  logic [3:0]  dmem_be;
  logic [4:0]  AddrD_out;
  logic        misalign_out, bus_err_out;
  logic [1:0]  state_dbg;

  // ---------------- timeout instance outputs ----------------
  logic        t_req, t_we, t_stall, t_valid_out, t_RegWEn_out;
  logic [31:0] t_addr, t_wdata, t_WB_Result_out;
  logic [3:0]  t_be;
  logic [4:0]  t_AddrD_out;
  logic        t_misalign_out, t_bus_err_out;
  logic [1:0]  t_state_dbg;

  ma_pipeline_lsu dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .RegWEn_in(RegWEn_in),
    .MemRW_in(MemRW_in), .WBSel_in(WBSel_in), .funct3_in(funct3_in),
    .ALU_Result_in(ALU_Result_in), .DataB_in(DataB_in), .pcPlus4_in(pcPlus4_in),
    .AddrD_in(AddrD_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .valid_out(valid_out), .RegWEn_out(RegWEn_out),
    .AddrD_out(AddrD_out), .WB_Result_out(WB_Result_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out), .state_dbg(state_dbg)
  );

  ma_pipeline_lsu #(.MAX_WAIT(4)) dut_t (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .RegWEn_in(RegWEn_in),
    .MemRW_in(MemRW_in), .WBSel_in(WBSel_in), .funct3_in(funct3_in),
    .ALU_Result_in(ALU_Result_in), .DataB_in(DataB_in), .pcPlus4_in(pcPlus4_in),
    .AddrD_in(AddrD_in), .dmem_req(t_req), .dmem_we(t_we),
    .dmem_addr(t_addr), .dmem_be(t_be), .dmem_wdata(t_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_out(t_stall), .valid_out(t_valid_out), .RegWEn_out(t_RegWEn_out),
    .AddrD_out(t_AddrD_out), .WB_Result_out(t_WB_Result_out),
    .misalign_out(t_misalign_out), .bus_err_out(t_bus_err_out),
    .state_dbg(t_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    valid_in = 1'b0; RegWEn_in = 1'b0; MemRW_in = 1'b0; WBSel_in = 2'b01;
    funct3_in = 3'b000; ALU_Result_in = 32'd0; DataB_in = 32'd0;
    pcPlus4_in = 32'd0; AddrD_in = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    tick();
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
    checks++; if (RegWEn_out !== 1'b0) begin errors++; $display("FAIL reset_regwen: got %0b want 0", RegWEn_out); end
    checks++; if (WB_Result_out !== 32'd0) begin errors++; $display("FAIL reset_wb: got %h want 0", WB_Result_out); end
    checks++; if (AddrD_out !== 5'd0) begin errors++; $display("FAIL reset_addrd: got %h want 0", AddrD_out); end
    checks++; if ({misalign_out, bus_err_out} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {misalign_out, bus_err_out}); end
    checks++; if ({dmem_req, stall_out} !== 2'b00) begin errors++; $display("FAIL reset_req_stall: got %b want 00", {dmem_req, stall_out}); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [1:0]  sel_t [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] exp_t [3] = '{32'h0000_1234, 32'h0000_2004, 32'h0000_1234};
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = sel_t[i];
      ALU_Result_in = 32'h0000_1234; pcPlus4_in = 32'h0000_2004; AddrD_in = 5'(5 + i);
      #1;
      checks++; if ({dmem_req, stall_out} !== 2'b00) begin errors++; $display("FAIL alu_no_req_stall[%0d]: got %b want 00", i, {dmem_req, stall_out}); end
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d]: got %0b want 1", i, valid_out); end
      checks++; if (WB_Result_out !== exp_t[i]) begin errors++; $display("FAIL alu_wb[%0d]: got %h want %h", i, WB_Result_out, exp_t[i]); end
      checks++; if ({RegWEn_out, AddrD_out} !== {1'b1, 5'(5 + i)}) begin errors++; $display("FAIL alu_dest[%0d]: got %b want %b", i, {RegWEn_out, AddrD_out}, {1'b1, 5'(5 + i)}); end
    end
    drive_idle();
    tick();
    checks++; if ({valid_out, RegWEn_out} !== 2'b00) begin errors++; $display("FAIL alu_bubble: got %b want 00", {valid_out, RegWEn_out}); end
  endtask

  task automatic test_store();
    logic [2:0]  f3_t   [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
    logic [31:0] adr_t  [4] = '{32'h103, 32'h101, 32'h102, 32'h00C};
    logic [31:0] dat_t  [4] = '{32'h0000_00A5, 32'h1234_5678, 32'h1234_BEEF, 32'h0102_0304};
    logic [3:0]  be_t   [4] = '{4'b1000, 4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wd_t   [4] = '{32'hA5A5_A5A5, 32'h7878_7878, 32'hBEEF_BEEF, 32'h0102_0304};
    logic [31:0] wa_t   [4] = '{32'h100, 32'h100, 32'h100, 32'h00C};
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; RegWEn_in = 1'b0; MemRW_in = 1'b1; WBSel_in = 2'b01;
      funct3_in = f3_t[i]; ALU_Result_in = adr_t[i]; DataB_in = dat_t[i];
      dmem_gnt = 1'b1;
      #1;
      checks++; if ({dmem_req, dmem_we, stall_out} !== 3'b110) begin errors++; $display("FAIL st_req_we_stall[%0d]: got %b want 110", i, {dmem_req, dmem_we, stall_out}); end
      checks++; if (dmem_be !== be_t[i]) begin errors++; $display("FAIL st_be[%0d]: got %b want %b", i, dmem_be, be_t[i]); end
      checks++; if (dmem_wdata !== wd_t[i]) begin errors++; $display("FAIL st_wdata[%0d]: got %h want %h", i, dmem_wdata, wd_t[i]); end
      checks++; if (dmem_addr !== wa_t[i]) begin errors++; $display("FAIL st_addr[%0d]: got %h want %h", i, dmem_addr, wa_t[i]); end
      tick();
      checks++; if ({valid_out, RegWEn_out} !== 2'b10) begin errors++; $display("FAIL st_retire[%0d]: got %b want 10", i, {valid_out, RegWEn_out}); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_load();
    logic [2:0]  f3_t  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b111, 3'b000};
    logic [31:0] adr_t [7] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h104, 32'h108, 32'h100};
    logic [31:0] rd_t  [7] = '{32'h0000_80FF, 32'h0000_80FF, 32'h8001_0000, 32'h8001_0000,
                              32'hCAFE_F00D, 32'h1357_2468, 32'h0000_007F};
    int          gc_t  [7] = '{3, 3, 0, 0, 1, 0, 0};
    int          rc_t  [7] = '{6, 6, 1, 1, 2, 1, 1};
    logic [31:0] exp_t [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                              32'hCAFE_F00D, 32'h1357_2468, 32'h0000_007F};
    int          st_t  [7] = '{6, 6, 1, 1, 2, 1, 1};
    int stalls;
    bit done;
    for (int i = 0; i < 7; i++) begin
      valid_in = 1'b1; RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = 2'b00;
      funct3_in = f3_t[i]; ALU_Result_in = adr_t[i]; AddrD_in = 5'(9 + i);
      dmem_rdata = rd_t[i];
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        dmem_gnt = (c == gc_t[i]); dmem_rvalid = (c == rc_t[i]);
        #1;
        if (c == 0) begin
          checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL ld_req[%0d]: got %0b want 1", i, dmem_req); end
        end
        if (stall_out) stalls++;
        else done = 1'b1;
        tick();
      end
      checks++; if (!done) begin errors++; $display("FAIL ld_timeout[%0d]: no retire within 20 cycles, want retire", i); end
      checks++; if (stalls != st_t[i]) begin errors++; $display("FAIL ld_stalls[%0d]: got %0d want %0d", i, stalls, st_t[i]); end
      checks++; if ({valid_out, RegWEn_out, AddrD_out} !== {2'b11, 5'(9 + i)}) begin errors++; $display("FAIL ld_retire[%0d]: got %b want %b", i, {valid_out, RegWEn_out, AddrD_out}, {2'b11, 5'(9 + i)}); end
      checks++; if (WB_Result_out !== exp_t[i]) begin errors++; $display("FAIL ld_wb[%0d]: got %h want %h", i, WB_Result_out, exp_t[i]); end
      drive_idle();
    end
    tick();
  endtask

  task automatic test_rvalid_rules();
    valid_in = 1'b1; RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = 2'b00;
    funct3_in = 3'b010; ALU_Result_in = 32'h100; AddrD_in = 5'd3;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL rv_with_gnt_stall: got %0b want 1", stall_out); end
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    checks++; if ({state_dbg, dmem_req, stall_out} !== {2'd2, 1'b0, 1'b1}) begin errors++; $display("FAIL rv_wait_state: got %b want 1001", {state_dbg, dmem_req, stall_out}); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rv_no_early_retire: got %0b want 0", valid_out); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rv_accept_stall: got %0b want 0", stall_out); end
    tick();
    checks++; if ({valid_out, WB_Result_out} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rv_accept_wb: got %0b/%h want 1/deadbeef", valid_out, WB_Result_out); end
    drive_idle();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0099;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rv_idle_ignored: got %0b want 0", valid_out); end
    drive_idle();
    tick();
  endtask

  task automatic test_misalign();
    logic [2:0]  f3_t  [3] = '{3'b010, 3'b001, 3'b101};
    logic        st_t  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] adr_t [3] = '{32'h102, 32'h101, 32'h103};
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; RegWEn_in = ~st_t[i]; MemRW_in = st_t[i];
      WBSel_in = st_t[i] ? 2'b01 : 2'b00; funct3_in = f3_t[i];
      ALU_Result_in = adr_t[i]; AddrD_in = 5'd20; dmem_gnt = 1'b1;
      #1;
      checks++; if ({dmem_req, stall_out} !== 2'b00) begin errors++; $display("FAIL mis_req_stall[%0d]: got %b want 00", i, {dmem_req, stall_out}); end
      tick();
      checks++; if ({valid_out, RegWEn_out, misalign_out} !== 3'b101) begin errors++; $display("FAIL mis_retire[%0d]: got %b want 101", i, {valid_out, RegWEn_out, misalign_out}); end
      drive_idle();
      tick();
      checks++; if ({valid_out, misalign_out} !== 2'b00) begin errors++; $display("FAIL mis_pulse_end[%0d]: got %b want 00", i, {valid_out, misalign_out}); end
    end
  endtask

  task automatic test_back_to_back();
    // ALU op, store with same-cycle grant, pc+4 select: one retire per edge.
    logic        st_t  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sel_t [3] = '{2'b01, 2'b01, 2'b10};
    logic [31:0] alu_t [3] = '{32'hAAAA_0001, 32'h0000_0040, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; RegWEn_in = ~st_t[i]; MemRW_in = st_t[i]; WBSel_in = sel_t[i];
      funct3_in = 3'b010; ALU_Result_in = alu_t[i]; pcPlus4_in = 32'h0000_3008;
      AddrD_in = 5'(i + 1); dmem_gnt = st_t[i];
      exp_q.push_back((sel_t[i] == 2'b10) ? 32'h0000_3008 : alu_t[i]);
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d]: got %0b want 0", i, stall_out); end
      tick();
      checks++; if ({valid_out, WB_Result_out} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL b2b_retire[%0d]: got %0b/%h want 1/%h", i, valid_out, WB_Result_out, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    drive_idle();
  endtask

  task automatic test_reset_in_wait();
    valid_in = 1'b1; RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = 2'b00;
    funct3_in = 3'b010; ALU_Result_in = 32'h300; AddrD_in = 5'd17; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    checks++; if ({state_dbg, stall_out} !== {2'd2, 1'b1}) begin errors++; $display("FAIL rst_pre_wait: got %b want 101", {state_dbg, stall_out}); end
    #1;
    reset_n = 1'b0; valid_in = 1'b0;
    #1;
    checks++; if ({valid_out, RegWEn_out, AddrD_out, WB_Result_out} !== 39'd0) begin errors++; $display("FAIL rst_async_outputs: got %0b %0b %h %h want all 0", valid_out, RegWEn_out, AddrD_out, WB_Result_out); end
    checks++; if ({state_dbg, dmem_req, stall_out} !== 4'b0000) begin errors++; $display("FAIL rst_async_state: got %b want 0000", {state_dbg, dmem_req, stall_out}); end
    tick();
    reset_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0077;
    tick();
    checks++; if ({valid_out, state_dbg} !== 3'b000) begin errors++; $display("FAIL rst_stray_rvalid: got %b want 000", {valid_out, state_dbg}); end
    drive_idle();
    tick();
  endtask

  task automatic test_timeout();
    int stalls;
    bit done;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    drive_idle();
    tick();
    valid_in = 1'b1; RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = 2'b00;
    funct3_in = 3'b010; ALU_Result_in = 32'h200; AddrD_in = 5'd30;
    stalls = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      checks++; if (t_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d]: got %0b want 1", c, t_req); end
      if (t_stall) stalls++;
      else done = 1'b1;
      tick();
    end
    checks++; if (!done) begin errors++; $display("FAIL to_no_abort: no abort within 20 cycles, want abort"); end
    checks++; if (stalls != 4) begin errors++; $display("FAIL to_stalls: got %0d want 4", stalls); end
    checks++; if ({t_valid_out, t_RegWEn_out, t_bus_err_out} !== 3'b101) begin errors++; $display("FAIL to_abort: got %b want 101", {t_valid_out, t_RegWEn_out, t_bus_err_out}); end
    drive_idle();
    #1;
    checks++; if ({t_req, t_state_dbg} !== 3'b000) begin errors++; $display("FAIL to_req_drop: got %b want 000", {t_req, t_state_dbg}); end
    tick();
    checks++; if ({t_valid_out, t_bus_err_out} !== 2'b00) begin errors++; $display("FAIL to_pulse_end: got %b want 00", {t_valid_out, t_bus_err_out}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_rvalid_rules();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
